// File: rtl/exec_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// exec_sequencer_pkg
// Shared definitions for the instruction sequencer: FSM state encoding,
// opcode constants, ALU operation constants and the decoded-control record
// that passes between the decoder and the sequencer.
// -----------------------------------------------------------------------------
package exec_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_e;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;

    localparam logic [2:0] ALUOP_FWD = 3'b000;
    localparam logic [2:0] ALUOP_ADD = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;

    // Control bundle produced by the decoder for one opcode.
    typedef struct packed {
        logic [2:0] aluop;
        logic       mux_2c;
        logic       mux_imm;
        logic       wr_en;    // opcode is a real instruction that writes back
    } ctrl_t;

    // Opcodes above OP_OR have no defined behaviour and never write.
    function automatic logic opcode_legal(input logic [7:0] opcode);
        return (opcode <= OP_OR);
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// -----------------------------------------------------------------------------
// exec_sequencer_if
// Bundles the instruction handshake and the register-file / ALU control
// outputs of the sequencer.
//   master : instruction requester (drives INSTR, INSTR_VALID, FLUSH)
//   slave  : the sequencer (drives READY, control outputs, BUSY)
// Optional macro EXEC_SEQ_ILLEGAL_EN adds the ILLEGAL flag.
// -----------------------------------------------------------------------------
interface exec_sequencer_if #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
);
    logic [31:0]           INSTR;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic                  FLUSH;
    logic [REG_ADDR_W-1:0] READREG1;
    logic [REG_ADDR_W-1:0] READREG2;
    logic [REG_ADDR_W-1:0] WRITEREG;
    logic                  WRITEENABLE;
    logic [2:0]            ALUOP;
    logic                  MUX_2C;
    logic                  MUX_IMM;
    logic [DATA_W-1:0]     IMMEDIATE;
    logic                  BUSY;
`ifdef EXEC_SEQ_ILLEGAL_EN
    logic                  ILLEGAL;
`endif

    modport master (
`ifdef EXEC_SEQ_ILLEGAL_EN
        input  ILLEGAL,
`endif
        output INSTR, INSTR_VALID, FLUSH,
        input  INSTR_READY, READREG1, READREG2, WRITEREG, WRITEENABLE,
        input  ALUOP, MUX_2C, MUX_IMM, IMMEDIATE, BUSY
    );

    modport slave (
`ifdef EXEC_SEQ_ILLEGAL_EN
        output ILLEGAL,
`endif
        input  INSTR, INSTR_VALID, FLUSH,
        output INSTR_READY, READREG1, READREG2, WRITEREG, WRITEENABLE,
        output ALUOP, MUX_2C, MUX_IMM, IMMEDIATE, BUSY
    );

endinterface

// File: rtl/exec_decode.sv
// -----------------------------------------------------------------------------
// exec_decode
// Purely combinational opcode-to-control mapping.
//   opcode : instruction opcode byte
//   ctrl   : ALU operation, operand muxes and write-back qualifier
// -----------------------------------------------------------------------------
module exec_decode
    import exec_sequencer_pkg::*;
(
    input  logic [7:0] opcode,
    output ctrl_t      ctrl
);

    // Map each opcode to its ALU controls; undefined opcodes decode to a no-op.
    always_comb begin
        ctrl.aluop   = ALUOP_FWD;
        ctrl.mux_2c  = 1'b0;
        ctrl.mux_imm = 1'b0;
        ctrl.wr_en   = opcode_legal(opcode);
        case (opcode)
            OP_LOADI: ctrl.mux_imm = 1'b1;
            OP_MOV:   ctrl.aluop   = ALUOP_FWD;
            OP_ADD:   ctrl.aluop   = ALUOP_ADD;
            OP_SUB: begin
                ctrl.aluop  = ALUOP_ADD;
                ctrl.mux_2c = 1'b1;     // a - b computed as a + (-b)
            end
            OP_AND:   ctrl.aluop   = ALUOP_AND;
            OP_OR:    ctrl.aluop   = ALUOP_OR;
            default:  ctrl.wr_en   = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
// Four-state instruction sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// One instruction is accepted per pass; decoded controls are captured at the
// accepting edge and held until the sequencer returns to IDLE.
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-low reset
//   bus   : exec_sequencer_if slave (handshake, FLUSH, control outputs)
// Optional macro EXEC_SEQ_ILLEGAL_EN: adds a sticky ILLEGAL flag and sends
// undefined opcodes straight from DECODE back to IDLE.
// -----------------------------------------------------------------------------
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    exec_sequencer_if.slave bus
);

    state_e                state_r;
    state_e                state_s;
    logic                  accept_s;
    logic                  we_s;
    ctrl_t                 dec_s;

    logic                  we_r;
    logic                  busy_r;
    logic [REG_ADDR_W-1:0] rr1_r;
    logic [REG_ADDR_W-1:0] rr2_r;
    logic [REG_ADDR_W-1:0] wr_r;
    logic [DATA_W-1:0]     imm_r;
    logic [2:0]            aluop_r;
    logic                  mux_2c_r;
    logic                  mux_imm_r;
    logic                  wr_en_r;

    // Decode straight from the incoming instruction so the result can be
    // captured at the accepting edge.
    exec_decode u_decode (
        .opcode (bus.INSTR[31:24]),
        .ctrl   (dec_s)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state, accept and write-strobe decisions.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        we_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.INSTR_VALID && !bus.FLUSH) begin
                    state_s  = ST_DECODE;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (bus.FLUSH) begin
                    state_s = ST_IDLE;
`ifdef EXEC_SEQ_ILLEGAL_EN
                end else if (!wr_en_r) begin
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (bus.FLUSH) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRITEBACK;
                    we_s    = wr_en_r;
                end
            end
            ST_WRITEBACK: state_s = ST_IDLE;
            default:      state_s = ST_IDLE;
        endcase
    end

    // Capture decoded controls on accept; clear them whenever the FSM idles.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            rr1_r     <= {REG_ADDR_W{1'b0}};
            rr2_r     <= {REG_ADDR_W{1'b0}};
            wr_r      <= {REG_ADDR_W{1'b0}};
            imm_r     <= {DATA_W{1'b0}};
            aluop_r   <= ALUOP_FWD;
            mux_2c_r  <= 1'b0;
            mux_imm_r <= 1'b0;
            wr_en_r   <= 1'b0;
        end else begin
            we_r   <= we_s;
            busy_r <= (state_s != ST_IDLE);
            if (accept_s) begin
                rr1_r     <= bus.INSTR[8 +: REG_ADDR_W];
                rr2_r     <= bus.INSTR[0 +: REG_ADDR_W];
                wr_r      <= bus.INSTR[16 +: REG_ADDR_W];
                imm_r     <= bus.INSTR[DATA_W-1:0];
                aluop_r   <= dec_s.aluop;
                mux_2c_r  <= dec_s.mux_2c;
                mux_imm_r <= dec_s.mux_imm;
                wr_en_r   <= dec_s.wr_en;
            end else if (state_s == ST_IDLE) begin
                rr1_r     <= {REG_ADDR_W{1'b0}};
                rr2_r     <= {REG_ADDR_W{1'b0}};
                wr_r      <= {REG_ADDR_W{1'b0}};
                imm_r     <= {DATA_W{1'b0}};
                aluop_r   <= ALUOP_FWD;
                mux_2c_r  <= 1'b0;
                mux_imm_r <= 1'b0;
                wr_en_r   <= 1'b0;
            end
        end
    end

`ifdef EXEC_SEQ_ILLEGAL_EN
    logic illegal_r;

    // Sticky flag: set when an undefined opcode is accepted, cleared only by reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            illegal_r <= 1'b0;
        end else if (accept_s && !dec_s.wr_en) begin
            illegal_r <= 1'b1;
        end
    end

    assign bus.ILLEGAL = illegal_r;
`endif

    // READY and the write strobe must react to FLUSH in the same cycle.
    assign bus.INSTR_READY = (state_r == ST_IDLE) && !bus.FLUSH;
    assign bus.WRITEENABLE = we_r && !bus.FLUSH;
    assign bus.BUSY        = busy_r;
    assign bus.READREG1    = rr1_r;
    assign bus.READREG2    = rr2_r;
    assign bus.WRITEREG    = wr_r;
    assign bus.IMMEDIATE   = imm_r;
    assign bus.ALUOP       = aluop_r;
    assign bus.MUX_2C      = mux_2c_r;
    assign bus.MUX_IMM     = mux_imm_r;

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
// Self-checking bench for exec_sequencer. A behavioural model tracks how many
// cycles have passed since the in-flight instruction was accepted and derives
// every expected output from the instruction's fields.
// Honours EXEC_SEQ_ILLEGAL_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exec_sequencer;

    localparam int DATA_W = 8;
    localparam int RA     = 3;

    logic CLK;
    logic RESET;

    exec_sequencer_if #(.DATA_W(DATA_W), .REG_ADDR_W(RA)) bus ();

    exec_sequencer #(.DATA_W(DATA_W), .REG_ADDR_W(RA)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: age = cycles since acceptance (1..3), -1 when idle.
    int          age      = -1;
    logic [31:0] cur      = 32'h0;
    logic        sticky   = 1'b0;
    int          cyc      = 0;
    int          acc_q[$];
    logic        last_we  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_aluop(input logic [7:0] op);
        case (op)
            8'd2, 8'd3: return 3'b001;
            8'd4:       return 3'b010;
            8'd5:       return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic check_outputs();
        logic [7:0] op;
        logic       act;
        op  = cur[31:24];
        act = (age >= 1);
        check_eq("ready", 32'(bus.INSTR_READY), 32'(!act && !bus.FLUSH));
        check_eq("busy",  32'(bus.BUSY), 32'(act));
        check_eq("we",    32'(bus.WRITEENABLE), 32'(act && age == 3 && op <= 8'd5 && !bus.FLUSH));
        check_eq("readreg1", 32'(bus.READREG1), act ? 32'(cur[8 +: RA])  : 32'h0);
        check_eq("readreg2", 32'(bus.READREG2), act ? 32'(cur[0 +: RA])  : 32'h0);
        check_eq("writereg", 32'(bus.WRITEREG), act ? 32'(cur[16 +: RA]) : 32'h0);
        check_eq("immediate", 32'(bus.IMMEDIATE), act ? 32'(cur[7:0]) : 32'h0);
        check_eq("aluop",   32'(bus.ALUOP),   act ? 32'(ref_aluop(op)) : 32'h0);
        check_eq("mux_2c",  32'(bus.MUX_2C),  32'(act && op == 8'd3));
        check_eq("mux_imm", 32'(bus.MUX_IMM), 32'(act && op == 8'd0));
`ifdef EXEC_SEQ_ILLEGAL_EN
        check_eq("illegal", 32'(bus.ILLEGAL), 32'(sticky));
`endif
        last_we = bus.WRITEENABLE;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        if (age < 0) begin
            if (bus.INSTR_VALID && !bus.FLUSH) begin
                age = 1;
                cur = bus.INSTR;
                acc_q.push_back(cyc);
                if (bus.INSTR[31:24] > 8'd5) sticky = 1'b1;
            end
        end else if (bus.FLUSH || age == 3) begin
            age = -1;
`ifdef EXEC_SEQ_ILLEGAL_EN
        end else if (age == 1 && cur[31:24] > 8'd5) begin
            age = -1;
`endif
        end else begin
            age = age + 1;
        end
        cyc++;
    endtask

    // Inputs are already driven just after a falling edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
        bus.INSTR_VALID = v;
        bus.INSTR       = ins;
        bus.FLUSH       = fl;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        RESET = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge CLK);
        #1;
        check_outputs();    // values held while reset is low

        // Release reset and present an instruction on the very first edge.
        RESET = 1'b1;
        drive(1'b1, 32'h03_02_01_05, 1'b0);    // sub r2, r1, r5
        step();
        check_eq("first_accept", 32'(age), 32'd1);
        drive(1'b0, 32'h0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (last_we && lat == 0) lat = k;
        end
        check_eq("sub_latency", 32'(lat), 32'd3);

        // loadi r4, 0xF6
        drive(1'b1, 32'h00_04_00_F6, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (4) step();

        // Two back-to-back adds with VALID held high.
        acc_q.delete();
        drive(1'b1, 32'h02_03_01_02, 1'b0);
        repeat (5) step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (4) step();
        check_eq("b2b_count", 32'(acc_q.size() >= 2), 32'd1);
        if (acc_q.size() >= 2) check_eq("b2b_gap", 32'(acc_q[1] - acc_q[0]), 32'd4);

        // FLUSH during EXECUTE of an add.
        drive(1'b1, 32'h02_06_07_01, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        step();
        check_eq("flush_idle", 32'(bus.INSTR_READY), 32'd1);

        // FLUSH together with VALID in IDLE must not accept.
        drive(1'b1, 32'h01_01_02_03, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        step();

        // Undefined opcode 0x07.
        drive(1'b1, 32'h07_05_04_03, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (5) step();

        // Reset asserted in the middle of EXECUTE.
        drive(1'b1, 32'h02_01_02_03, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        step();
        #2;
        RESET = 1'b0;
        age    = -1;
        sticky = 1'b0;
        #1;
        check_outputs();
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check_outputs();
        @(negedge CLK);
        RESET = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:24] = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) ins[31:24] = 8'($urandom_range(6, 255));
            drive(1'($urandom_range(0, 9) < 6), ins, 1'($urandom_range(0, 11) == 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, operand/immediate width; SHALL size IMMEDIATE.
REQ-002 Parameter REG_ADDR_W, default 3, register-file address width; SHALL size READREG1, READREG2 and WRITEREG.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset; SHALL take effect while low, independent of CLK.
REQ-005 INSTR  input  32  instruction: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/immediate.
REQ-006 INSTR_VALID  input  1  INSTR is valid this cycle.
REQ-007 INSTR_READY  output  1  sequencer is able to accept; a transfer SHALL occur when INSTR_VALID and INSTR_READY are both high at a rising edge.
REQ-008 FLUSH  input  1  synchronous abort of the in-flight instruction.
REQ-009 READREG1, READREG2  output  REG_ADDR_W  register-file read addresses.
REQ-010 WRITEREG  output  REG_ADDR_W  write address; WRITEENABLE  output  1  one-cycle write strobe.
REQ-011 ALUOP  output  3  000 forward, 001 add, 010 and, 011 or.
REQ-012 MUX_2C  output  1  selects the two's-complement of operand 2 (1) or the raw value (0).
REQ-013 MUX_IMM  output  1  selects IMMEDIATE (1) or the register operand (0) as ALU operand 2.
REQ-014 IMMEDIATE  output  DATA_W  INSTR[DATA_W-1:0] of the captured instruction.
REQ-015 BUSY  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, DECODE, EXECUTE and WRITEBACK.
REQ-017 Transition IDLE->DECODE SHALL occur on a transfer; DECODE->EXECUTE->WRITEBACK->IDLE SHALL each take exactly one cycle.
REQ-018 INSTR_READY SHALL be high only in IDLE with FLUSH low.
REQ-019 INSTR SHALL be registered on transfer; outputs SHALL be driven only from registered state, with no combinational path from INSTR.
REQ-020 Opcode decode SHALL be: 0 loadi (ALUOP 000, MUX_IMM 1); 1 mov (000, 0); 2 add (001, 0); 3 sub (001, MUX_2C 1); 4 and (010); 5 or (011).
REQ-021 Register fields SHALL use the low REG_ADDR_W bits of dest, src1 and src2.
REQ-022 Decoded outputs SHALL become valid in DECODE and SHALL be held constant through WRITEBACK.
REQ-023 WRITEENABLE SHALL be high only in the WRITEBACK cycle, giving a latency of 3 cycles from the transfer edge to the write strobe and a throughput of one instruction per 4 cycles.
REQ-024 Opcodes 6-255 SHALL follow the sequence with WRITEENABLE held low.
REQ-025 FLUSH high in DECODE, EXECUTE or WRITEBACK SHALL force IDLE at the next edge and suppress WRITEENABLE in that cycle.
REQ-026 FLUSH and INSTR_VALID both high in IDLE SHALL accept nothing.
REQ-027 INSTR_VALID asserted while BUSY SHALL be ignored; the instruction SHALL be neither dropped from the requester's view nor captured.

Reset
REQ-028 While RESET is low the state SHALL be IDLE, and all outputs SHALL be 0 except INSTR_READY, which SHALL be 1.
REQ-029 Reset asserted mid-instruction SHALL abort that instruction immediately, with no write strobe.
REQ-030 After RESET deasserts, the first transfer SHALL be accepted on the first rising edge.

Configuration
REQ-031 Macro EXEC_SEQ_ILLEGAL_EN: when defined, output ILLEGAL (1 bit) SHALL be added; it SHALL go high in DECODE for opcodes 6-255, stay sticky until reset, and leave the sequencer in IDLE after DECODE, skipping EXECUTE and WRITEBACK.
REQ-032 When EXEC_SEQ_ILLEGAL_EN is undefined, the ILLEGAL port SHALL be absent and REQ-024 behaviour SHALL apply.

Structure
REQ-033 A shared package SHALL hold the state encoding, the opcode constants 0-5 and the ALUOP constants.
REQ-034 One sub-module, exec_decode (combinational opcode-to-control mapping), SHALL be instantiated; the FSM SHALL remain in exec_sequencer.

Verification
REQ-035 RESET low mid-EXECUTE -> outputs 0 and INSTR_READY 1 immediately, with no WRITEENABLE.
REQ-036 INSTR 0x03_02_01_05 (sub r2,r1,r5) -> READREG1 1, READREG2 5, ALUOP 001, MUX_2C 1, WRITEREG 2, WRITEENABLE high exactly 3 cycles after transfer.
REQ-037 INSTR 0x00_04_00_F6 (loadi r4,0xF6) -> MUX_IMM 1, IMMEDIATE 0xF6, ALUOP 000, write to r4.
REQ-038 INSTR_VALID held high for two back-to-back adds -> second accepted 4 cycles after first; BUSY pattern 1,1,1,0.
REQ-039 FLUSH pulsed in EXECUTE of add -> no WRITEENABLE, IDLE next cycle, INSTR_READY 1.
REQ-040 Opcode 0x07 -> no write; with EXEC_SEQ_ILLEGAL_EN defined, ILLEGAL=1 sticky and IDLE after 2 cycles.
